// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage with bubble/flush control zeroing
// and a saturating count of cycles stalled by downstream backpressure.
module pipe_stage_reg #(
    parameter int DATA_W = 102,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_reg,     state_next;
    logic [CTRL_W-1:0]  main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0]  main_data_reg, main_data_next;
    logic [CTRL_W-1:0]  skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0]  skid_data_reg, skid_data_next;
    logic [CNT_W-1:0]   stall_cnt_reg, stall_cnt_next;

    logic in_fire;
    logic out_fire;

    // Handshake flags come only from registered state, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_reg != TWO);
    assign out_valid = (state_reg != EMPTY);
    assign out_ctrl  = main_ctrl_reg;
    assign out_data  = main_data_reg;
    assign stall_cnt = stall_cnt_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        stall_cnt_next = stall_cnt_reg;

        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next     = ONE;
                    main_ctrl_next = in_ctrl;
                    main_data_next = in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_ctrl_next = in_ctrl;
                    main_data_next = in_data;
                end else if (in_fire) begin
                    state_next     = TWO;
                    skid_ctrl_next = in_ctrl;
                    skid_data_next = in_data;
                end else if (out_fire) begin
                    state_next     = EMPTY;
                    main_ctrl_next = '0;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_next     = ONE;
                    main_ctrl_next = skid_ctrl_reg;
                    main_data_next = skid_data_reg;
                    skid_ctrl_next = '0;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase

        // Flush wins over every handshake in the same cycle.
        if (flush) begin
            state_next     = EMPTY;
            main_ctrl_next = '0;
            main_data_next = '0;
            skid_ctrl_next = '0;
            skid_data_next = '0;
        end

        if (out_valid && !out_ready && !flush && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, all
// checked against a two-slot FIFO queue model of the stage.
module tb_pipe_stage_reg;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    pipe_stage_reg #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t q[$];
    int   model_cnt;
    int   tests_run;
    int   tests_failed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(q.size() < 2));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(model_cnt));
        check({tag, ".out_ctrl"},  32'(out_ctrl),  (q.size() > 0) ? 32'(q[0].c) : 32'd0);
        if (q.size() > 0)
            check({tag, ".out_data"}, 32'(out_data), 32'(q[0].d));
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input string tag, input logic v, input logic [CTRL_W-1:0] c,
                        input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
        int  pre_size;
        bit  ifire;
        bit  ofire;
        ent_t e;
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        pre_size  = q.size();
        ifire     = v && (pre_size < 2);
        ofire     = (pre_size > 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (ofire) void'(q.pop_front());
            if (ifire) begin
                e.c = c;
                e.d = d;
                q.push_back(e);
            end
        end
        if (pre_size > 0 && !ordy && !fl && model_cnt < CNT_MAX)
            model_cnt++;
        check_all(tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        model_cnt    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state, before and after a clock edge under reset
        #2;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.out_data",  32'(out_data),  32'd0);
        check("reset.out_ctrl",  32'(out_ctrl),  32'd0);
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #1;
        check_all("reset_edge");
        rst = 1'b1;

        // Streaming with out_ready held high
        step("stream1", 1'b1, 2'b11, 8'h01, 1'b1, 1'b0);
        check("stream1.data", 32'(out_data), 32'h01);
        step("stream2", 1'b1, 2'b11, 8'h02, 1'b1, 1'b0);
        check("stream2.data", 32'(out_data), 32'h02);
        step("stream3", 1'b1, 2'b11, 8'h03, 1'b1, 1'b0);
        check("stream3.data", 32'(out_data), 32'h03);
        step("stream4", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        check("stream.stall", 32'(stall_cnt), 32'd0);

        // Backpressure fills the skid entry; A3 waits upstream
        step("bp_a1", 1'b1, 2'b01, 8'hA1, 1'b0, 1'b0);
        step("bp_a2", 1'b1, 2'b10, 8'hA2, 1'b0, 1'b0);
        check("bp.in_ready_two", 32'(in_ready), 32'd0);
        step("bp_hold", 1'b1, 2'b11, 8'hA3, 1'b0, 1'b0);
        step("bp_out1", 1'b1, 2'b11, 8'hA3, 1'b1, 1'b0);
        check("bp.head_a2", 32'(out_data), 32'hA2);
        step("bp_out2", 1'b1, 2'b11, 8'hA3, 1'b1, 1'b0);
        check("bp.head_a3", 32'(out_data), 32'hA3);
        step("bp_out3", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

        // Flush from TWO beats a concurrent push
        step("fl_b1", 1'b1, 2'b11, 8'hB1, 1'b0, 1'b0);
        step("fl_b2", 1'b1, 2'b11, 8'hB2, 1'b0, 1'b0);
        step("fl_kill", 1'b1, 2'b11, 8'hB3, 1'b1, 1'b1);
        check("flush.out_data", 32'(out_data), 32'd0);
        check("flush.out_ctrl", 32'(out_ctrl), 32'd0);
        step("fl_after", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

        // Drain from ONE with nothing behind it
        step("drain_d1", 1'b1, 2'b10, 8'hD1, 1'b1, 1'b0);
        step("drain_out", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        check("drain.out_ctrl", 32'(out_ctrl), 32'd0);

        // Stall counter saturation
        step("stall_fill", 1'b1, 2'b01, 8'h5A, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step("stall_hold", 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("stall.saturated", 32'(stall_cnt), 32'(CNT_MAX));

        // Asynchronous reset between edges while in TWO
        step("ar_fill", 1'b1, 2'b11, 8'hE2, 1'b0, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        q.delete();
        model_cnt = 0;
        check("areset.out_valid", 32'(out_valid), 32'd0);
        check("areset.out_data",  32'(out_data),  32'd0);
        check("areset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("areset.in_ready",  32'(in_ready),  32'd1);
        #1;
        rst = 1'b1;
        step("ar_c1", 1'b1, 2'b01, 8'hC1, 1'b1, 1'b0);
        check("areset.c1", 32'(out_data), 32'hC1);
        step("ar_drain", 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 CTRL_W'($urandom),
                 DATA_W'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 102, payload bits passed through unmodified (data, address, writeback-index fields).
REQ-002 Parameter CTRL_W, default 3, control bits forced to zero when a bubble or flush is inserted (reg-write, mem-to-reg selects).
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 Clocking: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous active-low reset; 0 = reset asserted.
REQ-007 flush  in  1  synchronous kill of stage contents, active-high.
REQ-008 in_valid  in  1  upstream presents a valid entry.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  upstream control bits.
REQ-011 in_data  in  DATA_W  upstream payload.
REQ-012 out_valid  out  1  stage presents a valid entry downstream.
REQ-013 out_ready  in  1  downstream accepts this cycle.
REQ-014 out_ctrl  out  CTRL_W  control bits of head entry; all zero when out_valid=0.
REQ-015 out_data  out  DATA_W  payload of head entry.
REQ-016 stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Storage SHALL be two entries: main (head, drives outputs) and skid; each holds ctrl+data.
REQ-018 State machine SHALL have states EMPTY, ONE (main full), TWO (main and skid full).
REQ-019 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, decoded from registered state only (no combinational path from out_ready).
REQ-021 out_valid SHALL be 1 in ONE and TWO, 0 in EMPTY; out_ctrl, out_data SHALL be main register outputs.
REQ-022 EMPTY: in_fire -> ONE, main <= input; else stay.
REQ-023 ONE: in_fire & out_fire -> ONE, main <= input; in_fire only -> TWO, skid <= input; out_fire only -> EMPTY, main ctrl <= 0; neither -> stay.
REQ-024 TWO: out_fire -> ONE, main <= skid, skid ctrl <= 0; else stay (no input accepted).
REQ-025 Latency SHALL be 1 cycle: an entry accepted at edge N is on out_* after edge N when stage was EMPTY or drains that cycle.
REQ-026 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush.
REQ-027 flush=1 at an edge SHALL force EMPTY and zero both ctrl fields; any in_fire or out_fire that cycle is ignored; data fields are zeroed.
REQ-028 flush has priority over all handshakes; in_ready follows state, so it reads 1 in the cycle after a flush.
REQ-029 stall_cnt SHALL increment by 1 on each edge with out_valid=1 & out_ready=0 & flush=0, saturating at 2^CNT_W-1; it is not cleared by flush.
REQ-030 Payload bits SHALL never be altered while stored; ctrl is zeroed only per REQ-023, REQ-024, REQ-027.

Reset
REQ-031 While rst=0, immediately and independently of clk: state EMPTY, main and skid ctrl and data 0, stall_cnt 0; hence out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
REQ-032 Reset asserted mid-transfer SHALL discard both entries; the first edge after rst returns to 1 behaves as EMPTY.

Verification (bench: DATA_W=8, CTRL_W=2, CNT_W=4)
REQ-033 Streaming: out_ready=1, in_valid=1 with data 0x01,0x02,0x03, ctrl 2'b11 -> out_data 0x01,0x02,0x03 on consecutive cycles one cycle late, in_ready=1 throughout, stall_cnt=0.
REQ-034 Backpressure: out_ready=0, push 0xA1 then 0xA2 -> state TWO, in_ready=0, 0xA3 held upstream; raise out_ready -> 0xA1,0xA2,0xA3 out in order, none lost.
REQ-035 Flush: stage in TWO (0xB1,0xB2), flush=1 with in_valid=1 data 0xB3 -> next cycle out_valid=0, out_ctrl=2'b00, in_ready=1; 0xB3 never appears at output.
REQ-036 Stall count: out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 (saturated), not 4.
REQ-037 Async reset: stage in TWO, drop rst between edges -> out_valid=0, out_data=0x00, stall_cnt=0 before the next edge; release rst, push 0xC1 -> 0xC1 out after one edge.
REQ-038 Drain: ONE holding 0xD1, out_fire with in_valid=0 -> EMPTY, out_ctrl=2'b00, out_valid=0.
